core_mem_arb: RTL and testbench

CORE_MEM_ARB -- requirements
Module: core_mem_arb

---
 rtl/core_mem_arb_pkg.sv | 18 +
 rtl/core_mem_arb.sv | 80 ++++++++
 tb/tb_core_mem_arb.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arb_pkg.sv
// core_mem_arb_pkg: shared core defines (instruction types, opcodes, arbiter states and defaults)
package core_mem_arb_pkg;
  typedef logic [31:0] instr_t;
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_t;
  typedef enum logic [1:0] {IDLE, FETCH, DATA} arb_state_t;
  localparam int ARB_TIMEOUT = 255;
  localparam int ARB_STARVE_MAX = 4;
endpackage

// File: rtl/core_mem_arb.sv
// core_mem_arb: arbitrates fetch and data requests onto one memory bus with anti-starvation and timeout
module core_mem_arb
  import core_mem_arb_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_halt,
  input  logic        mau_req,
  input  logic        mau_we,
  input  logic [31:0] mau_addr,
  input  logic [31:0] mau_wdata,
  input  logic [3:0]  mau_be,
  output logic        mau_ack,
  output logic [31:0] mau_rdata,
  output logic        ex_halt,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);
  arb_state_t state, state_nxt;
  logic [2:0] starve_cnt;
  logic [7:0] wait_cnt;
  logic grant_data, grant_fetch, tmo, done;
  // grant choice, completion strobes, acks and next state; a real bus_ack always beats the timeout
  always_comb begin
    grant_data = mau_req & (~if_req | (int'(starve_cnt) < STARVE_MAX));
    grant_fetch = if_req & ~grant_data;
    tmo = wait_cnt == 8'(TIMEOUT);
    done = (state != IDLE) & (bus_ack | tmo);
    bus_err = done & ~bus_ack;
    if_ack = done & (state == FETCH);
    mau_ack = done & (state == DATA);
    if_rdata = if_ack & bus_ack ? bus_rdata : '0;
    mau_rdata = mau_ack & bus_ack ? bus_rdata : '0;
    if_halt = if_req & ~if_ack;
    ex_halt = mau_req & ~mau_ack;
    state_nxt = state == IDLE ? (grant_data ? DATA : grant_fetch ? FETCH : IDLE) : done ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // launch bus cycle from the granted requester, track starvation and bus wait time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      bus_be <= '0;
      starve_cnt <= '0;
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
      if (grant_data | grant_fetch) begin
        bus_req <= 1'b1;
        bus_we <= grant_data & mau_we;
        bus_addr <= grant_data ? mau_addr : if_addr;
        bus_wdata <= grant_data ? mau_wdata : '0;
        bus_be <= grant_data ? mau_be : 4'hF;
        starve_cnt <= grant_data & if_req ? (&starve_cnt ? starve_cnt : starve_cnt + 3'd1) : '0;
      end
    end else begin
      wait_cnt <= done ? '0 : wait_cnt + 8'd1;
      if (done) bus_req <= 1'b0;
    end
  end
endmodule

// File: tb/tb_core_mem_arb.sv
// tb_core_mem_arb: randomized transaction-level check of core_mem_arb against a request/grant model
module tb_core_mem_arb;
  localparam int TO = 255;
  localparam int SM = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_halt;
  logic        mau_req = 1'b0;
  logic        mau_we = 1'b0;
  logic [31:0] mau_addr = '0;
  logic [31:0] mau_wdata = '0;
  logic [3:0]  mau_be = '0;
  logic        mau_ack;
  logic [31:0] mau_rdata;
  logic        ex_halt;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err;

  core_mem_arb #(.TIMEOUT(TO), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_halt(if_halt),
    .mau_req(mau_req), .mau_we(mau_we), .mau_addr(mau_addr), .mau_wdata(mau_wdata), .mau_be(mau_be),
    .mau_ack(mau_ack), .mau_rdata(mau_rdata), .ex_halt(ex_halt),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit p_if, p_mau, m_we;
  logic [31:0] ia, ma, mw;
  logic [3:0] mbe;
  int starve_m = 0;
  bit grants[$];

  task automatic drive();
    if_req = p_if;
    if_addr = ia;
    mau_req = p_mau;
    mau_we = m_we;
    mau_addr = ma;
    mau_wdata = mw;
    mau_be = mbe;
  endtask

  task automatic new_if();
    p_if = 1;
    ia = $urandom;
  endtask

  task automatic new_mau();
    p_mau = 1;
    m_we = 1'($urandom_range(0, 1));
    ma = $urandom;
    mw = $urandom;
    mbe = 4'($urandom);
  endtask

  // one bus transaction: expected grant from the model, ack after lat wait cycles, then requester update
  task automatic do_txn(input int lat, input int mode, input logic [31:0] rd);
    bit ed, ewe, got;
    logic [31:0] ea, ew;
    logic [3:0] ebe;
    ed = p_mau && (!p_if || starve_m < SM);
    ewe = ed && m_we;
    ea = ed ? ma : ia;
    ew = mw;
    ebe = ed ? mbe : 4'hF;
    got = 0;
    bus_rdata = $urandom | 32'h1;
    for (int i = 0; i < 3 && !got; i++) begin
      @(posedge clk); #1;
      got = bus_req;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL txn_grant: bus_req=%b after 3 cycles, want 1", bus_req);
      return;
    end
    for (int i = 0; i <= lat; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == lat) begin bus_ack = 1; bus_rdata = rd; end
      #1;
      n_chk++;
      if ({bus_req, bus_we, bus_addr, bus_be} !== {1'b1, ewe, ea, ebe} || (ed && bus_wdata !== ew)) begin
        n_fail++;
        $display("FAIL txn_bus: req=%b we=%b addr=%h be=%h wdata=%h, want 1 %b %h %h %h", bus_req, bus_we, bus_addr, bus_be, bus_wdata, ewe, ea, ebe, ew);
      end
      n_chk++;
      if (i < lat) begin
        if ({if_ack, mau_ack, bus_err, if_rdata, mau_rdata} !== '0 || if_halt !== p_if || ex_halt !== p_mau) begin
          n_fail++;
          $display("FAIL txn_wait: ack=%b%b err=%b rd=%h/%h halt=%b%b, want 00 0 0/0 %b%b", if_ack, mau_ack, bus_err, if_rdata, mau_rdata, if_halt, ex_halt, p_if, p_mau);
        end
      end else if ({if_ack, mau_ack, bus_err} !== {!ed, ed, 1'b0} || if_rdata !== (ed ? 32'h0 : rd) ||
                   mau_rdata !== (ed ? rd : 32'h0) || if_halt !== (p_if && ed) || ex_halt !== (p_mau && !ed)) begin
        n_fail++;
        $display("FAIL txn_ack: if_ack=%b mau_ack=%b err=%b if_rd=%h mau_rd=%h halt=%b%b, data_grant=%b rd=%h", if_ack, mau_ack, bus_err, if_rdata, mau_rdata, if_halt, ex_halt, ed, rd);
      end
    end
    @(posedge clk); #1;
    bus_ack = 0;
    grants.push_back(ed);
    starve_m = (ed && p_if) ? (starve_m < 7 ? starve_m + 1 : 7) : 0;
    if (ed) p_mau = 0; else p_if = 0;
    if (mode == 0 || (mode == 1 && $urandom_range(0, 1) == 1)) begin
      if (ed) new_mau(); else new_if();
    end
    if (mode == 1) begin
      if (!p_if && $urandom_range(0, 2) == 0) new_if();
      if (!p_mau && $urandom_range(0, 2) == 0) new_mau();
      if (!p_if && !p_mau) new_mau();
    end
    if (mode == 2) begin p_if = 0; p_mau = 0; end
    drive();
    #1;
    n_chk++;
    if ({bus_req, if_ack, mau_ack, bus_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL txn_gap: req=%b acks=%b%b err=%b, want all 0", bus_req, if_ack, mau_ack, bus_err);
    end
  endtask

  task automatic test_reset();
    p_if = 1; p_mau = 1; ia = 32'h40; ma = 32'h80; mw = 32'h5; mbe = 4'hF; m_we = 1;
    drive();
    bus_ack = 1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err, if_ack, mau_ack, if_rdata, mau_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h be=%h err=%b acks=%b%b, want all 0", bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err, if_ack, mau_ack);
    end
    n_chk++;
    if ({if_halt, ex_halt} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_halts: if_halt=%b ex_halt=%b, want 1 1", if_halt, ex_halt);
    end
    @(negedge clk);
    rst = 1;
    #1;
    n_chk++;
    if (bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL release_no_grant: bus_req=%b before first edge, want 0", bus_req);
    end
    p_if = 0; p_mau = 0;
    drive();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({bus_req, if_ack, mau_ack, bus_err} !== 4'b0) begin
        n_fail++;
        $display("FAIL idle_ack_ignored: req=%b acks=%b%b err=%b, want 0", bus_req, if_ack, mau_ack, bus_err);
      end
    end
    bus_ack = 0;
  endtask

  task automatic test_single_fetch();
    p_mau = 0; p_if = 1; ia = 32'h100;
    drive();
    do_txn(2, 2, 32'hDEADBEEF);
  endtask

  task automatic test_store();
    p_if = 0; p_mau = 1; m_we = 1; ma = 32'h2000; mw = 32'h12345678; mbe = 4'b0011;
    drive();
    do_txn(3, 2, 32'h0BAD_F00D);
  endtask

  task automatic test_simultaneous();
    bit exp_g [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    grants.delete();
    new_if();
    new_mau();
    drive();
    for (int k = 0; k < 10; k++) do_txn(0, 0, $urandom);
    for (int k = 0; k < 10; k++) begin
      n_chk++;
      if (k >= grants.size() || grants[k] != exp_g[k]) begin
        n_fail++;
        $display("FAIL simul_order[%0d]: data_grant=%b, want %b", k, k < grants.size() ? grants[k] : 1'b0, exp_g[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) do_txn($urandom_range(0, 3), k == 39 ? 2 : 1, $urandom);
  endtask

  task automatic test_timeout(input bit ack_b);
    bit got, fin, stable, early;
    int at;
    logic got_err;
    logic [31:0] got_rd;
    got = 0; fin = 0; stable = 1; early = 0; at = -1; got_err = 1'bx; got_rd = 'x;
    p_if = 0;
    new_mau();
    drive();
    for (int i = 0; i < 3 && !got; i++) begin
      @(posedge clk); #1;
      got = bus_req;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL tmo_grant: bus_req=%b, want 1", bus_req);
    end
    bus_rdata = 32'hCAFEF00D;
    for (int i = 0; i <= TO + 4 && !fin; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      bus_ack = ack_b && i == TO;
      #1;
      if (bus_req !== 1'b1 || bus_addr !== ma) stable = 0;
      if (mau_ack === 1'b1) begin
        fin = 1; at = i; got_err = bus_err; got_rd = mau_rdata;
      end else if (bus_err !== 1'b0) early = 1;
    end
    n_chk++;
    if (at != TO) begin
      n_fail++;
      $display("FAIL tmo_cycle(ack=%b): mau_ack at cycle %0d, want %0d", ack_b, at, TO);
    end
    n_chk++;
    if (got_err !== !ack_b || got_rd !== (ack_b ? 32'hCAFEF00D : 32'h0)) begin
      n_fail++;
      $display("FAIL tmo_result(ack=%b): bus_err=%b mau_rdata=%h, want %b %h", ack_b, got_err, got_rd, !ack_b, ack_b ? 32'hCAFEF00D : 32'h0);
    end
    n_chk++;
    if (!stable || early) begin
      n_fail++;
      $display("FAIL tmo_hold(ack=%b): stable=%b early_err=%b, want 1 0", ack_b, stable, early);
    end
    @(posedge clk); #1;
    bus_ack = 0;
    p_mau = 0;
    starve_m = 0;
    drive();
    #1;
    n_chk++;
    if ({bus_req, bus_err, mau_ack} !== 3'b0) begin
      n_fail++;
      $display("FAIL tmo_idle(ack=%b): req=%b err=%b mau_ack=%b, want 0 0 0", ack_b, bus_req, bus_err, mau_ack);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    got = 0;
    p_if = 0;
    new_mau();
    drive();
    for (int i = 0; i < 3 && !got; i++) begin
      @(posedge clk); #1;
      got = bus_req;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL rmid_grant: bus_req=%b, want 1", bus_req);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    bus_ack = 1;
    bus_rdata = 32'h1111_2222;
    #1;
    n_chk++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err, if_ack, mau_ack, mau_rdata} !== '0) begin
      n_fail++;
      $display("FAIL rmid_async: req=%b we=%b addr=%h wd=%h be=%h err=%b acks=%b%b rd=%h, want all 0", bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err, if_ack, mau_ack, mau_rdata);
    end
    @(posedge clk); #1;
    n_chk++;
    if ({bus_req, mau_ack} !== 2'b0) begin
      n_fail++;
      $display("FAIL rmid_held: req=%b mau_ack=%b, want 0 0", bus_req, mau_ack);
    end
    @(negedge clk); #1;
    bus_ack = 0;
    rst = 1;
    p_mau = 0;
    starve_m = 0;
    new_if();
    drive();
    do_txn(1, 2, $urandom);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_random();
    test_timeout(0);
    test_timeout(1);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
